fifo_rr_arb: RTL and testbench
==============================

# fifo_rr_arb

- Round-robin burst arbiter that merges `num_ports` upstream 16-deep `fifo` output ports onto one registered output with the same `valid_out`/`deq` protocol.
- Sits between several producer FIFOs and a single shared consumer (e.g. a DMA or link framer).
- Grants one port for a burst of up to `max_burst` words, then rotates priority.
- A per-port enable mask lets software remove ports from arbitration.

## Interface
- `fifo_width`, 32, data word width
- `num_ports`, 4, number of requesting FIFOs (2..8)
- `max_burst`, 4, maximum words moved per grant (1..16)
- `clk` input 1: single clock, all logic on rising edge
- `rst` input 1: reset, asynchronous, active-high
- `in_data` input `num_ports*fifo_width`: port i head word at bits [i*fifo_width +: fifo_width]
- `in_valid` input `num_ports`: upstream FIFO `valid_out` per port
- `in_deq` output `num_ports`: combinational pop to upstream FIFO; at most one bit high
- `port_en` input `num_ports`: arbitration enable mask; a disabled port is treated as `in_valid`=0
- `data_out` output `fifo_width`: registered output word
- `valid_out` output 1: `data_out` holds an undelivered word
- `deq` input 1: consumer takes `data_out` this cycle; ignored when `valid_out`=0
- `grant_active` output 1: registered; high while in BURST
- `grant_id` output clog2(`num_ports`): registered; port currently or last granted

## Operation
- `req[i]` = `in_valid[i]` & `port_en[i]`.
- `slot_free` = !`valid_out` | `deq`.
- A transfer loads `in_data[sel]` into `data_out`, sets `valid_out`, and pulses `in_deq[sel]` the same cycle.
- Without a transfer: if `deq`, then `valid_out` <= 0; `data_out` holds its value.
- State IDLE:
  - if `slot_free` and any `req`, select the first requesting port at or after `rr_ptr` (wrapping num_ports-1 -> 0) and transfer.
  - `grant_id` <= sel, `burst_cnt` <= 1.
  - if `max_burst`=1, stay IDLE and set `rr_ptr` <= sel+1 (mod num_ports); else go to BURST.
- State BURST, port g = `grant_id`:
  - `req[g]` low: release with no transfer this cycle; `rr_ptr` <= g+1, go to IDLE.
  - `req[g]` high and `slot_free`: transfer from g, `burst_cnt`++. If the new count equals `max_burst`, `rr_ptr` <= g+1 and go to IDLE.
  - `req[g]` high and !`slot_free`: hold; no `in_deq`.
- Other ports are never popped during BURST.
- `rr_ptr` advances only at grant end, never on an idle cycle.
- `port_en` deasserted mid-burst behaves as `req[g]` low: release next cycle.
- `in_deq` is never asserted for a port whose `req` is low.

## Timing
- Reset (async assert, sync-safe release): `valid_out`=0, `data_out`=0, `grant_active`=0, `grant_id`=0, `in_deq`=0, state IDLE, `rr_ptr`=0, `burst_cnt`=0.
- Latency: a word present on `in_data` with `req` high at edge N appears on `data_out` with `valid_out` after edge N. One cycle input-to-output.
- Throughput: one word per cycle within a burst while the consumer holds `deq` high.
- Simultaneous `deq` and a transfer: the new word replaces the old one; no bubble.
- Release costs one idle cycle in BURST; a burst ending on count costs none: IDLE arbitrates on the next cycle.
- Reset mid-burst drops the grant and any undelivered `data_out`. Upstream words already popped are lost; this is acceptable.
- `in_deq` depends only on registered state, `in_valid`, `port_en` and `deq`. There is no combinational path from `in_data`.

## Test plan
- Reset, all `req` low -> `valid_out`=0, `data_out`=0, `in_deq`=0, `grant_id`=0 for 10 cycles.
- 4 ports, each continuously valid with words 0xA0.., 0xB0.., 0xC0.., 0xD0.., `deq` tied high, `max_burst`=4 -> output A0..A3, B0..B3, C0..C3, D0..D3, A4...; one word per cycle after the first.
- Port 1 only, 2 words, `max_burst`=4 -> 2 transfers; one release cycle (`in_deq`=0) with `grant_active` then low; `rr_ptr`=2, so a later simultaneous request by ports 0 and 2 grants port 2 first.
- Consumer stalls (`deq`=0) for 5 cycles mid-burst -> `data_out` stable, `in_deq` all 0, `burst_cnt` unchanged; resumes with no lost or duplicated word.
- `port_en[2]` cleared while port 2 is in BURST -> no `in_deq[2]` after that cycle; next grant goes to port 3; port 2 is never selected while disabled.
- Assert `rst` asynchronously mid-burst (not on a clock edge) -> outputs reach reset values before the next edge; after release, arbitration restarts at port 0.

Source files
------------

// File: rtl/fifo_rr_arb.sv
// Round-robin burst arbiter merging several FIFO output ports
// onto one registered valid/deq output.
module fifo_rr_arb #(
  parameter int fifo_width = 32,
  parameter int num_ports  = 4,
  parameter int max_burst  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [num_ports*fifo_width-1:0] in_data,
  input  logic [num_ports-1:0]            in_valid,
  output logic [num_ports-1:0]            in_deq,
  input  logic [num_ports-1:0]            port_en,
  output logic [fifo_width-1:0]           data_out,
  output logic                            valid_out,
  input  logic                            deq,
  output logic                            grant_active,
  output logic [$clog2(num_ports)-1:0]    grant_id
);

  localparam int GW = $clog2(num_ports);
  localparam int CW = $clog2(max_burst + 1);
  localparam logic [CW-1:0] MB = CW'(max_burst);
  localparam logic [GW-1:0] LAST = GW'(num_ports - 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e                state_q, state_d;
  logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]         grant_id_q, grant_id_d;
  logic [CW-1:0]         burst_cnt_q, burst_cnt_d;
  logic [fifo_width-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic [num_ports-1:0]  req;
  logic [GW-1:0]         pick;
  logic [GW-1:0]         sel;
  logic                  slot_free;
  logic                  xfer;

  function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign req       = in_valid & port_en;
  assign slot_free = !valid_q || deq;

  // Scan downward so the requester closest to rr_ptr wins last.
  always_comb begin
    pick = '0;
    for (int i = num_ports - 1; i >= 0; i--) begin
      if (req[(int'(rr_ptr_q) + i) % num_ports])
        pick = GW'((int'(rr_ptr_q) + i) % num_ports);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    xfer        = 1'b0;
    sel         = grant_id_q;
    unique case (state_q)
      IDLE: begin
        if (slot_free && |req) begin
          xfer        = 1'b1;
          sel         = pick;
          grant_id_d  = pick;
          burst_cnt_d = CW'(1);
          if (max_burst == 1)
            rr_ptr_d = wrap_inc(pick);
          else
            state_d = BURST;
        end
      end
      BURST: begin
        if (!req[grant_id_q]) begin
          rr_ptr_d = wrap_inc(grant_id_q);
          state_d  = IDLE;
        end else if (slot_free) begin
          xfer        = 1'b1;
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (burst_cnt_d == MB) begin
            rr_ptr_d = wrap_inc(grant_id_q);
            state_d  = IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    in_deq  = '0;
    data_d  = data_q;
    valid_d = valid_q;
    if (xfer) begin
      in_deq[sel] = 1'b1;
      data_d      = in_data[int'(sel)*fifo_width +: fifo_width];
      valid_d     = 1'b1;
    end else if (deq) begin
      valid_d = 1'b0;
    end
  end

  assign data_out     = data_q;
  assign valid_out    = valid_q;
  assign grant_active = (state_q == BURST);
  assign grant_id     = grant_id_q;

endmodule

// File: tb/tb_fifo_rr_arb.sv
// Scoreboard bench for fifo_rr_arb: queue-based source FIFOs,
// a grant-level reference model, and an independent output monitor.
module tb_fifo_rr_arb;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int MB = 4;
  localparam int GW = $clog2(N);

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0] in_valid = '0;
  logic [N-1:0] port_en = '0;
  logic         deq = 1'b0;
  logic [N-1:0] in_deq;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         grant_active;
  logic [GW-1:0] grant_id;

  fifo_rr_arb #(
    .fifo_width(W),
    .num_ports(N),
    .max_burst(MB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_deq(in_deq),
    .port_en(port_en),
    .data_out(data_out),
    .valid_out(valid_out),
    .deq(deq),
    .grant_active(grant_active),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [W-1:0] src [N][$];
  logic [W-1:0] sb [$];
  logic [W-1:0] outlog [$];

  // Grant-level model: who owns the output, words moved, next start port.
  int owner = -1;
  int taken = 0;
  int start = 0;
  int mgid = 0;
  bit mvalid = 1'b0;

  int dq_pct = 100;
  int en_pct = 100;
  logic [N-1:0] en_mask = '1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  function automatic bit busy();
    bit b;
    b = (sb.size() != 0) || (owner >= 0) || mvalid;
    for (int i = 0; i < N; i++)
      if (src[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_valid[i] = (src[i].size() != 0);
      in_data[i*W +: W] = (src[i].size() != 0) ? src[i][0] : W'($urandom);
      port_en[i] = en_mask[i] && (int'($urandom_range(99)) < en_pct);
    end
    deq = (int'($urandom_range(99)) < dq_pct);
  endtask

  task automatic step();
    int exp_p;
    logic [N-1:0] mreq;
    logic [N-1:0] exp_deq;
    bit sfree;
    @(negedge clk);
    drive();
    #2;
    for (int i = 0; i < N; i++)
      mreq[i] = (src[i].size() != 0) && port_en[i];
    sfree = !mvalid || deq;
    chk("valid_out", valid_out, mvalid);
    chk("grant_active", grant_active, owner >= 0);
    chk("grant_id", grant_id, mgid);
    exp_p = -1;
    if (owner < 0) begin
      if (sfree && mreq != 0) begin
        for (int k = 0; k < N; k++) begin
          if (mreq[(start + k) % N]) begin
            exp_p = (start + k) % N;
            break;
          end
        end
        mgid = exp_p;
        taken = 1;
        if (MB == 1) start = (exp_p + 1) % N;
        else owner = exp_p;
      end
    end else if (!mreq[owner]) begin
      start = (owner + 1) % N;
      owner = -1;
    end else if (sfree) begin
      exp_p = owner;
      taken++;
      if (taken == MB) begin
        start = (owner + 1) % N;
        owner = -1;
      end
    end
    exp_deq = '0;
    if (exp_p >= 0) exp_deq[exp_p] = 1'b1;
    chk("in_deq", in_deq, exp_deq);
    if (exp_p >= 0) begin
      sb.push_back(src[exp_p].pop_front());
      mvalid = 1'b1;
    end else if (deq) begin
      mvalid = 1'b0;
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    dq_pct = 100;
    en_pct = 100;
    en_mask = '1;
    while (busy() && n < 200) begin
      step();
      n++;
    end
    #2;
    chk(nm, busy(), 0);
  endtask

  // Output monitor: every delivered word must be the oldest expected one.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (valid_out === 1'b1 && deq === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_extra: got %0h want none", data_out);
        end else begin
          e = sb.pop_front();
          chk("data_out", data_out, e);
        end
        outlog.push_back(data_out);
      end
    end
  end

  initial begin
    logic [W-1:0] held;
    logic [W-1:0] ew;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // idle after reset
    dq_pct = 0;
    repeat (10) begin
      step();
      chk("rst_data", data_out, 0);
      chk("rst_in_deq", in_deq, 0);
    end

    // four ports streaming with deq held high
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 12; k++)
        src[i].push_back(W'(32'hA0 + i*16 + k));
    dq_pct = 100;
    outlog.delete();
    repeat (49) step();
    #2;
    chk("stream_count", outlog.size(), 48);
    for (int j = 0; j < 17; j++) begin
      ew = W'(32'hA0 + ((j/4) % 4)*16 + (j/16)*4 + (j % 4));
      if (j < outlog.size()) chk("stream_order", outlog[j], ew);
    end
    chk("stream_idle", busy(), 0);

    // single port runs dry mid-burst, then rr_ptr check
    src[1].push_back(32'h11);
    src[1].push_back(32'h12);
    repeat (3) step();
    chk("release_gact", grant_active, 1);
    chk("release_deq", in_deq, 0);
    step();
    chk("release_done", grant_active, 0);
    src[0].push_back(32'h01);
    src[2].push_back(32'h21);
    step();
    chk("rr_after_release", in_deq, 4'b0100);
    drain("drain_release");

    // consumer stall mid-burst
    for (int k = 0; k < 8; k++) src[3].push_back(W'(32'h30 + k));
    step();
    step();
    dq_pct = 0;
    step();
    held = data_out;
    chk("stall_word", held, 32'h31);
    repeat (4) begin
      step();
      chk("stall_hold", data_out, held);
      chk("stall_no_deq", in_deq, 0);
    end
    drain("drain_stall");

    // port 2 disabled mid-burst
    for (int k = 0; k < 8; k++) src[2].push_back(W'(32'h50 + k));
    step();
    step();
    for (int k = 0; k < 4; k++) src[3].push_back(W'(32'h60 + k));
    en_mask = 4'b1011;
    step();
    chk("en_release", in_deq, 0);
    step();
    chk("en_next_p3", in_deq, 4'b1000);
    repeat (6) begin
      step();
      chk("en_no_p2", in_deq[2], 0);
    end
    drain("drain_en");

    // randomized traffic, stalls and enable flicker
    dq_pct = 60;
    en_pct = 85;
    repeat (3000) begin
      for (int i = 0; i < N; i++)
        if (src[i].size() < 16 && $urandom_range(99) < 30)
          src[i].push_back($urandom);
      step();
    end
    drain("drain_random");

    // asynchronous reset in the middle of a burst
    for (int k = 0; k < 8; k++) src[1].push_back(W'(32'h70 + k));
    step();
    step();
    @(negedge clk);
    in_valid = '0;
    port_en = '0;
    deq = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", valid_out, 0);
    chk("arst_data", data_out, 0);
    chk("arst_gact", grant_active, 0);
    chk("arst_gid", grant_id, 0);
    chk("arst_deq", in_deq, 0);
    owner = -1;
    taken = 0;
    start = 0;
    mgid = 0;
    mvalid = 1'b0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    src[0].push_back(32'h0F);
    step();
    chk("arst_restart_p0", in_deq, 4'b0001);
    drain("drain_arst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
